stopwatch_ctrl: RTL and testbench

Control sequencer for the stopwatch datapath. It debounces the three raw push-buttons and runs the IDLE/RUN/PAUSE state machine. It generates the 10 ms count-enable tick, the one-cycle clear pulse and the display-load level. The BCD counter chain and the display shadow registers are driven only by this block's outputs; they never see raw keys.

---
 rtl/stopwatch_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: key synchronise/debounce, IDLE/RUN/PAUSE FSM, tick prescaler,
// clear pulse and display-load level. The lap/freeze key is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV     = 500000,
    parameter int unsigned DEBOUNCE_CYC = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_reset_n,
    input  logic       key_start_pause_n,
    input  logic       key_lap_n,
    input  logic       max_reached,
    output logic       tick,
    output logic       clear,
    output logic       disp_load,
    output logic [1:0] state
);

    localparam int unsigned PW    = $clog2(TICK_DIV);
    localparam int unsigned CW    = $clog2(DEBOUNCE_CYC);
    localparam int unsigned K_RST = 0;
    localparam int unsigned K_STA = 1;
`ifdef STOPWATCH_LAP_EN
    localparam int unsigned K_LAP = 2;
    localparam int unsigned NK    = 3;
`else
    localparam int unsigned NK    = 2;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    logic [NK-1:0] key_raw;
    logic [NK-1:0] sync1_q, sync2_q;
    logic [NK-1:0] level_q, level_d;
    logic [NK-1:0] armed_q, armed_d;
    logic [NK-1:0] press_q, press_d;
    logic [CW-1:0] dbc_q [NK];
    logic [CW-1:0] dbc_d [NK];

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          clear_q, clear_d;
    logic          tick_due;
    logic          ev_reset, ev_start;

`ifdef STOPWATCH_LAP_EN
    logic          disp_q, disp_d;
    logic          ev_lap;

    assign key_raw = {key_lap_n, key_start_pause_n, key_reset_n};
    assign ev_lap  = press_q[K_LAP];
`else
    logic          unused_key_lap;

    assign key_raw        = {key_start_pause_n, key_reset_n};
    assign unused_key_lap = key_lap_n;
`endif

    assign ev_reset = press_q[K_RST];
    assign ev_start = press_q[K_STA];
    assign tick_due = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));

    // A key is ignored until it has been seen released once after reset, so a key held
    // through reset release cannot fire; after that, each accepted 1->0 flip is one press.
    always_comb begin
        level_d = level_q;
        armed_d = armed_q | sync2_q;
        press_d = '0;
        for (int k = 0; k < int'(NK); k++) begin
            dbc_d[k] = '0;
            if (armed_q[k] && (sync2_q[k] != level_q[k])) begin
                if (dbc_q[k] == CW'(DEBOUNCE_CYC - 1)) begin
                    level_d[k] = sync2_q[k];
                    press_d[k] = ~sync2_q[k];
                end else begin
                    dbc_d[k] = dbc_q[k] + 1'b1;
                end
            end
        end
    end

    // Next state, prescaler and outputs; ev_reset is applied last so it overrides everything.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        clear_d = 1'b0;
`ifdef STOPWATCH_LAP_EN
        disp_d  = disp_q;
`endif
        case (state_q)
            IDLE: begin
                presc_d = '0;
                if (ev_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                presc_d = tick_due ? '0 : presc_q + 1'b1;
                tick_d  = tick_due && !max_reached;
                if (ev_start || (tick_due && max_reached)) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (ev_start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
            end
        endcase
`ifdef STOPWATCH_LAP_EN
        if (ev_lap && (state_q != IDLE)) begin
            disp_d = ~disp_q;
        end
`endif
        if (ev_reset) begin
            state_d = IDLE;
            presc_d = '0;
            tick_d  = 1'b0;
            clear_d = 1'b1;
`ifdef STOPWATCH_LAP_EN
            disp_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '1;
            armed_q <= '0;
            press_q <= '0;
            for (int k = 0; k < int'(NK); k++) begin
                dbc_q[k] <= '0;
            end
            state_q <= IDLE;
            presc_q <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            disp_q  <= 1'b1;
`endif
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
            for (int k = 0; k < int'(NK); k++) begin
                dbc_q[k] <= dbc_d[k];
            end
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            clear_q <= clear_d;
`ifdef STOPWATCH_LAP_EN
            disp_q  <= disp_d;
`endif
        end
    end

    assign tick  = tick_q;
    assign clear = clear_q;
    assign state = state_q;
`ifdef STOPWATCH_LAP_EN
    assign disp_load = disp_q;
`else
    assign disp_load = 1'b1;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (TICK_DIV=5, DEBOUNCE_CYC=4) with tick/clear scoreboards.
module tb_stopwatch_ctrl;

    localparam int TDIV = 5;
    localparam int N    = 60;
`ifdef STOPWATCH_LAP_EN
    localparam int LAP_EXP = 0;
`else
    localparam int LAP_EXP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_reset_n = 1'b1;
    logic       key_start_pause_n = 1'b1;
    logic       key_lap_n = 1'b1;
    logic       max_reached = 1'b0;
    logic       tick, clear, disp_load;
    logic [1:0] state;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;
    int n_fail = 0;
    int exp_tick[$];
    int exp_clear[$];

    stopwatch_ctrl #(.TICK_DIV(5), .DEBOUNCE_CYC(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .key_reset_n       (key_reset_n),
        .key_start_pause_n (key_start_pause_n),
        .key_lap_n         (key_lap_n),
        .max_reached       (max_reached),
        .tick              (tick),
        .clear             (clear),
        .disp_load         (disp_load),
        .state             (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Expected ticks for a RUN stretch entered at cycle r with a partial period of a counts
    // already accumulated; a tick shows every TDIV cycles spent in RUN, none after cycle last.
    task automatic plan_run(input int r, input int a, input int last);
        for (int c = r + 1; c <= last; c++) begin
            if ((c - r + a) % TDIV == 0) exp_tick.push_back(c);
        end
    endtask

    // Every cycle, tick and clear must match the scoreboard exactly.
    always @(negedge clk) begin
        if (exp_tick.size() > 0 && exp_tick[0] == cyc) begin
            void'(exp_tick.pop_front());
            chk("tick_due", int'(tick), 1);
        end else begin
            chk("tick_none", int'(tick), 0);
        end
        if (exp_clear.size() > 0 && exp_clear[0] == cyc) begin
            void'(exp_clear.pop_front());
            chk("clear_due", int'(clear), 1);
        end else begin
            chk("clear_none", int'(clear), 0);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cyc(3);
        chk("rst_state", int'(state), 0);
        chk("rst_disp", int'(disp_load), 1);
        rst_n = 1'b1;
        wait_cyc(53);
        chk("idle_state", int'(state), 0);
        chk("idle_disp", int'(disp_load), 1);

        // start with a clean 10-cycle press, then short bounces
        wait_cyc(N + 0);
        key_start_pause_n = 1'b0;
        plan_run(N + 7, 0, N + 54);
        wait_cyc(N + 6);
        chk("start_lat_before", int'(state), 0);
        wait_cyc(N + 7);
        chk("start_lat_run", int'(state), 1);
        wait_cyc(N + 10);
        key_start_pause_n = 1'b1;
        for (int b = 0; b < 3; b++) begin
            wait_cyc(N + 20 + 4 * b);
            key_start_pause_n = 1'b0;
            wait_cyc(N + 22 + 4 * b);
            key_start_pause_n = 1'b1;
        end
        wait_cyc(N + 40);
        chk("bounce_no_event", int'(state), 1);

        // pause with 2 counts pending, resume: 3 RUN cycles to the next tick
        wait_cyc(N + 47);
        key_start_pause_n = 1'b0;
        wait_cyc(N + 53);
        chk("pause_before", int'(state), 1);
        wait_cyc(N + 54);
        chk("pause_state", int'(state), 2);
        wait_cyc(N + 55);
        key_start_pause_n = 1'b1;
        wait_cyc(N + 65);
        key_start_pause_n = 1'b0;
        plan_run(N + 72, 2, N + 99);
        wait_cyc(N + 71);
        chk("resume_before", int'(state), 2);
        wait_cyc(N + 72);
        chk("resume_state", int'(state), 1);
        wait_cyc(N + 73);
        key_start_pause_n = 1'b1;

        // reset and start together in RUN, landing on a due tick
        wait_cyc(N + 93);
        key_reset_n = 1'b0;
        key_start_pause_n = 1'b0;
        exp_clear.push_back(N + 100);
        wait_cyc(N + 99);
        chk("rst_start_before", int'(state), 1);
        wait_cyc(N + 100);
        chk("rst_start_idle", int'(state), 0);
        chk("rst_start_disp", int'(disp_load), 1);
        wait_cyc(N + 101);
        chk("rst_start_after", int'(state), 0);
        key_reset_n = 1'b1;
        key_start_pause_n = 1'b1;

        // fresh start (prescaler zeroed), then max_reached suppresses the next tick
        wait_cyc(N + 115);
        key_start_pause_n = 1'b0;
        plan_run(N + 122, 0, N + 131);
        wait_cyc(N + 122);
        chk("restart_run", int'(state), 1);
        wait_cyc(N + 123);
        key_start_pause_n = 1'b1;
        wait_cyc(N + 128);
        max_reached = 1'b1;
        wait_cyc(N + 131);
        chk("max_before", int'(state), 1);
        wait_cyc(N + 132);
        chk("max_pause", int'(state), 2);
        wait_cyc(N + 135);
        max_reached = 1'b0;

        // asynchronous reset with start held across its release
        wait_cyc(N + 138);
        key_start_pause_n = 1'b0;
        wait_cyc(N + 140);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_disp", int'(disp_load), 1);
        chk("async_rst_tick", int'(tick), 0);
        chk("async_rst_clear", int'(clear), 0);
        wait_cyc(N + 143);
        rst_n = 1'b1;
        wait_cyc(N + 165);
        chk("held_key_no_event", int'(state), 0);
        wait_cyc(N + 170);
        key_start_pause_n = 1'b1;

        // lap: ignored in IDLE, toggles in RUN, forced to 1 by reset
        wait_cyc(N + 180);
        key_lap_n = 1'b0;
        wait_cyc(N + 188);
        key_lap_n = 1'b1;
        wait_cyc(N + 190);
        chk("lap_idle", int'(disp_load), 1);
        wait_cyc(N + 195);
        key_start_pause_n = 1'b0;
        plan_run(N + 202, 0, N + 256);
        exp_clear.push_back(N + 257);
        wait_cyc(N + 202);
        chk("lap_run_state", int'(state), 1);
        wait_cyc(N + 203);
        key_start_pause_n = 1'b1;
        wait_cyc(N + 205);
        key_lap_n = 1'b0;
        wait_cyc(N + 211);
        chk("lap1_before", int'(disp_load), 1);
        wait_cyc(N + 212);
        chk("lap1_freeze", int'(disp_load), LAP_EXP);
        wait_cyc(N + 213);
        key_lap_n = 1'b1;
        wait_cyc(N + 222);
        key_lap_n = 1'b0;
        wait_cyc(N + 229);
        chk("lap2_track", int'(disp_load), 1);
        wait_cyc(N + 230);
        key_lap_n = 1'b1;
        wait_cyc(N + 238);
        key_lap_n = 1'b0;
        wait_cyc(N + 245);
        chk("lap3_freeze", int'(disp_load), LAP_EXP);
        wait_cyc(N + 246);
        key_lap_n = 1'b1;
        wait_cyc(N + 250);
        key_reset_n = 1'b0;
        wait_cyc(N + 256);
        chk("lap_rst_before_st", int'(state), 1);
        chk("lap_rst_before_dl", int'(disp_load), LAP_EXP);
        wait_cyc(N + 257);
        chk("lap_rst_state", int'(state), 0);
        chk("lap_rst_disp", int'(disp_load), 1);
        wait_cyc(N + 258);
        key_reset_n = 1'b1;

        // final start from IDLE after a key reset
        wait_cyc(N + 270);
        key_start_pause_n = 1'b0;
        plan_run(N + 277, 0, N + 290);
        wait_cyc(N + 277);
        chk("final_run", int'(state), 1);
        wait_cyc(N + 278);
        key_start_pause_n = 1'b1;
        wait_cyc(N + 291);
        chk("tick_sb_drained", exp_tick.size(), 0);
        chk("clear_sb_drained", exp_clear.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
